// File: rtl/control_pipeline.sv
// E/M/W control pipeline between decoder and datapath, with an output-port
// handshake that can freeze E and M and a retired-instruction counter.
module control_pipeline #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   validD,
  input  logic                   isVectorScalarOperationED,
  input  logic                   useInmediateED,
  input  logic                   isScalarInstructionED,
  input  logic [2:0]             aluControlED,
  input  logic                   writeToMemoryEnableMD,
  input  logic                   outFlagMD,
  input  logic                   resultSelectorWBD,
  input  logic                   writeEnableScalarWBD,
  input  logic                   writeEnableVectorWBD,
  input  logic                   stallD,
  input  logic                   flushE,
  input  logic                   outReady,
  input  logic                   clearCount,
  output logic                   isVectorScalarOperationE,
  output logic                   useInmediateE,
  output logic                   isScalarInstructionE,
  output logic [2:0]             aluControlE,
  output logic                   writeToMemoryEnableM,
  output logic                   outValid,
  output logic                   resultSelectorW,
  output logic                   writeEnableScalarW,
  output logic                   writeEnableVectorW,
  output logic                   pipelineStall,
  output logic [COUNT_WIDTH-1:0] retiredCount
);

  typedef struct packed {
    logic resultSelector;
    logic writeEnableScalar;
    logic writeEnableVector;
  } wbCtrl_t;

  typedef struct packed {
    logic    writeToMemoryEnable;
    logic    outFlag;
    wbCtrl_t wb;
  } memCtrl_t;

  typedef struct packed {
    logic       isVectorScalarOperation;
    logic       useInmediate;
    logic       isScalarInstruction;
    logic [2:0] aluControl;
    memCtrl_t   mem;
  } exCtrl_t;

  exCtrl_t  dCtrl, ctrlE;
  memCtrl_t ctrlM;
  wbCtrl_t  ctrlW;
  logic     validE, validM, validW;
  logic     holdOut;

  // Invalid decode slots are forced to a clean bubble so x never propagates.
  always_comb begin
    dCtrl = '0;
    if (validD)
      dCtrl = {isVectorScalarOperationED, useInmediateED, isScalarInstructionED,
               aluControlED, writeToMemoryEnableMD, outFlagMD,
               resultSelectorWBD, writeEnableScalarWBD, writeEnableVectorWBD};
  end

  assign holdOut = validM & ctrlM.outFlag & ~outReady;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      validE <= 1'b0;
      validM <= 1'b0;
      validW <= 1'b0;
      ctrlE  <= '0;
      ctrlM  <= '0;
      ctrlW  <= '0;
    end else if (holdOut) begin
      // E and M freeze behind the blocked output transfer; W drains.
      validW <= 1'b0;
      ctrlW  <= '0;
    end else begin
      validM <= validE;
      ctrlM  <= ctrlE.mem;
      validW <= validM;
      ctrlW  <= ctrlM.wb;
      if (flushE || stallD) begin
        validE <= 1'b0;
        ctrlE  <= '0;
      end else begin
        validE <= validD;
        ctrlE  <= dCtrl;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      retiredCount <= '0;
    else if (clearCount)
      retiredCount <= '0;
    else if (validW)
      retiredCount <= retiredCount + COUNT_WIDTH'(1);
  end

  assign isVectorScalarOperationE = ctrlE.isVectorScalarOperation;
  assign useInmediateE            = ctrlE.useInmediate;
  assign isScalarInstructionE     = ctrlE.isScalarInstruction;
  assign aluControlE              = ctrlE.aluControl;
  assign writeToMemoryEnableM     = validM & ctrlM.writeToMemoryEnable;
  assign outValid                 = validM & ctrlM.outFlag;
  assign resultSelectorW          = ctrlW.resultSelector;
  assign writeEnableScalarW       = validW & ctrlW.writeEnableScalar;
  assign writeEnableVectorW       = validW & ctrlW.writeEnableVector;
  assign pipelineStall            = stallD | holdOut;

endmodule

// File: tb/tb_control_pipeline.sv
// Directed bench for control_pipeline: latency, output handshake hold,
// stall/flush bubbles, counter wrap/clear and asynchronous reset.
module tb_control_pipeline;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst, validD, isVectorScalarOperationED, useInmediateED, isScalarInstructionED;
  logic [2:0] aluControlED;
  logic writeToMemoryEnableMD, outFlagMD, resultSelectorWBD, writeEnableScalarWBD;
  logic writeEnableVectorWBD, stallD, flushE, outReady, clearCount;
  logic isVectorScalarOperationE, useInmediateE, isScalarInstructionE;
  logic [2:0] aluControlE;
  logic writeToMemoryEnableM, outValid, resultSelectorW, writeEnableScalarW;
  logic writeEnableVectorW, pipelineStall;
  logic [CW-1:0] retiredCount;
  logic [11:0] outVec;

  int nCmp = 0;
  int nBad = 0;

  control_pipeline #(.COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .validD(validD),
    .isVectorScalarOperationED(isVectorScalarOperationED),
    .useInmediateED(useInmediateED), .isScalarInstructionED(isScalarInstructionED),
    .aluControlED(aluControlED), .writeToMemoryEnableMD(writeToMemoryEnableMD),
    .outFlagMD(outFlagMD), .resultSelectorWBD(resultSelectorWBD),
    .writeEnableScalarWBD(writeEnableScalarWBD), .writeEnableVectorWBD(writeEnableVectorWBD),
    .stallD(stallD), .flushE(flushE), .outReady(outReady), .clearCount(clearCount),
    .isVectorScalarOperationE(isVectorScalarOperationE), .useInmediateE(useInmediateE),
    .isScalarInstructionE(isScalarInstructionE), .aluControlE(aluControlE),
    .writeToMemoryEnableM(writeToMemoryEnableM), .outValid(outValid),
    .resultSelectorW(resultSelectorW), .writeEnableScalarW(writeEnableScalarW),
    .writeEnableVectorW(writeEnableVectorW), .pipelineStall(pipelineStall),
    .retiredCount(retiredCount)
  );

  always #5 clk = ~clk;

  assign outVec = {isVectorScalarOperationE, useInmediateE, isScalarInstructionE, aluControlE,
                   writeToMemoryEnableM, outValid, resultSelectorW, writeEnableScalarW,
                   writeEnableVectorW, pipelineStall};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clrD();
    validD = 0; isVectorScalarOperationED = 0; useInmediateED = 0; isScalarInstructionED = 0;
    aluControlED = 3'b000; writeToMemoryEnableMD = 0; outFlagMD = 0; resultSelectorWBD = 0;
    writeEnableScalarWBD = 0; writeEnableVectorWBD = 0; stallD = 0; flushE = 0;
  endtask

  task automatic xD();
    validD = 0; stallD = 0; flushE = 0;
    isVectorScalarOperationED = 'x; useInmediateED = 'x; isScalarInstructionED = 'x;
    aluControlED = 'x; writeToMemoryEnableMD = 'x; outFlagMD = 'x; resultSelectorWBD = 'x;
    writeEnableScalarWBD = 'x; writeEnableVectorWBD = 'x;
  endtask

  initial begin
    rst = 0; xD(); outReady = 0; clearCount = 0;
    #12;
    chk("rstOuts", outVec, 0);
    chk("rstCount", retiredCount, 0);

    // First edge after reset release loads D
    rst = 1; clrD(); validD = 1; aluControlED = 3'b101;
    tick();
    chk("firstLoadAlu", aluControlE, 3'b101);

    // Invalid decode with x fields: everything stays a known 0
    xD();
    repeat (4) begin
      tick();
      chk("invalidNoX", outVec, 0);
    end
    chk("invalidCount", retiredCount, 1);
    clearCount = 1; tick(); clearCount = 0;
    chk("clear", retiredCount, 0);

    // Back-to-back instructions
    clrD(); validD = 1; aluControlED = 3'b001;
    tick();
    chk("b2bAluE", aluControlE, 3'b001);
    clrD(); validD = 1; writeEnableVectorWBD = 1;
    tick();
    chk("b2bAluE2", aluControlE, 3'b000);
    clrD();
    tick();
    chk("b2bWeVearly", writeEnableVectorW, 0);
    tick();
    chk("b2bWeV", writeEnableVectorW, 1);
    tick();
    chk("b2bCount", retiredCount, 2);

    // Output handshake held off for three cycles
    clrD(); validD = 1; outFlagMD = 1;
    tick();
    clrD(); validD = 1; useInmediateED = 1; resultSelectorWBD = 1; writeEnableScalarWBD = 1;
    tick();
    clrD(); validD = 1; aluControlED = 3'b111;
    for (int i = 0; i < 3; i++) begin
      chk("hsOutValid", outValid, 1);
      chk("hsStall", pipelineStall, 1);
      chk("hsHeldE", useInmediateE, 1);
      chk("hsIgnoreD", aluControlE, 0);
      chk("hsBubbleW", {resultSelectorW, writeEnableScalarW, writeEnableVectorW}, 0);
      if (i < 2) tick();
    end
    clrD(); outReady = 1;
    #1;
    chk("hsStallDrop", pipelineStall, 0);
    tick();
    chk("hsOutValidOff", outValid, 0);
    tick();
    chk("hsResSel", resultSelectorW, 1);
    chk("hsWeS", writeEnableScalarW, 1);
    tick();
    chk("hsCount", retiredCount, 4);

    // Stall and flush together: bubble into E
    clrD(); validD = 1; isScalarInstructionED = 1; writeEnableScalarWBD = 1;
    stallD = 1; flushE = 1;
    #1;
    chk("sfStall", pipelineStall, 1);
    tick();
    chk("sfBubbleE", isScalarInstructionE, 0);
    clrD();
    repeat (3) begin
      tick();
      chk("sfNoWeS", writeEnableScalarW, 0);
    end
    chk("sfCount", retiredCount, 4);

    // Counter: fill to all-ones, wrap, then clear-wins
    clearCount = 1; tick(); clearCount = 0;
    clrD(); validD = 1;
    repeat (15) tick();
    clrD();
    repeat (4) tick();
    chk("cntFull", retiredCount, 15);
    validD = 1;
    tick();
    clrD();
    repeat (3) tick();
    chk("cntWrap", retiredCount, 0);
    validD = 1;
    tick();
    clrD();
    tick(); tick();
    clearCount = 1; tick(); clearCount = 0;
    chk("cntClearWins", retiredCount, 0);

    // Asynchronous reset mid-operation with a pending output transfer
    outReady = 0;
    clrD(); validD = 1;
    tick();
    clrD(); validD = 1; writeToMemoryEnableMD = 1; outFlagMD = 1;
    tick();
    clrD();
    tick();
    chk("arWmem", writeToMemoryEnableM, 1);
    chk("arOutValid", outValid, 1);
    tick();
    chk("arPreCount", retiredCount, 1);
    #2;
    rst = 0;
    #1;
    chk("arWmemDrop", writeToMemoryEnableM, 0);
    chk("arOutValidDrop", outValid, 0);
    chk("arCount", retiredCount, 0);
    chk("arOuts", outVec, 0);
    #10;
    rst = 1;
    tick();
    chk("arNoReplay", outValid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
